chroma_seq: RTL and testbench

// - Line/field sequencer driving the composite chroma generator: produces hsync, burst gate, colour-enable

---
 rtl/chroma_pkg.sv | 45 ++++
 rtl/chroma_seq_hv_cnt.sv | 62 ++++++
 rtl/chroma_seq.sv | 169 ++++++++++++++++
 tb/tb_chroma_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_pkg.sv
// ----------------------------------------------------------------------------
// chroma_pkg
// Shared types and default timing for the chroma line/field sequencer.
//   seg_e          : line segment states of the sequencer FSM
//   PNSEL_*        : encoding of the PAL/NTSC standard select
//   DEF_*          : default timing in pixel clocks for CLK_FREQ
//   umin()         : unsigned minimum for elaboration-time parameter checks
// ----------------------------------------------------------------------------
package chroma_pkg;

    localparam int unsigned HCNT_W = 11;
    localparam int unsigned VCNT_W = 9;

    typedef enum logic [2:0] {
        SEG_SYNC,
        SEG_PORCH,
        SEG_BURST,
        SEG_ACTIVE,
        SEG_FRONT
    } seg_e;

    localparam logic PNSEL_PAL  = 1'b0;
    localparam logic PNSEL_NTSC = 1'b1;

    // Line totals follow from the pixel clock; the intra-line offsets below
    // are tuned for 28 MHz and must be rescaled together with CLK_FREQ.
    localparam int unsigned CLK_FREQ   = 28_000_000;
    localparam int unsigned CLK_PER_US = CLK_FREQ / 1_000_000;

    localparam int unsigned DEF_H_TOTAL_PAL  = 64 * CLK_PER_US;          // 64.0 us
    localparam int unsigned DEF_H_TOTAL_NTSC = (127 * CLK_PER_US) / 2;   // 63.5 us
    localparam int unsigned DEF_HSYNC_LEN    = 132;
    localparam int unsigned DEF_BURST_START  = 157;
    localparam int unsigned DEF_BURST_LEN    = 63;
    localparam int unsigned DEF_ACTIVE_START = 294;
    localparam int unsigned DEF_ACTIVE_END   = 1747;
    localparam int unsigned DEF_V_TOTAL_PAL  = 312;
    localparam int unsigned DEF_V_TOTAL_NTSC = 262;
    localparam int unsigned DEF_VSYNC_LINES  = 3;

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/chroma_seq_hv_cnt.sv
// ----------------------------------------------------------------------------
// chroma_seq_hv_cnt
// Horizontal/vertical position counters for chroma_seq.
//   i_clk          in   pixel clock
//   i_rst_n        in   synchronous active-low reset
//   i_pnsel        in   standard in effect (selects line and field length)
//   o_hcnt         out  position within line, 0..HT-1
//   o_vcnt         out  line within field, 0..VT-1
//   o_line_start   out  high while hcnt == 0
//   o_field_start  out  high while hcnt == 0 and vcnt == 0
// ----------------------------------------------------------------------------
module chroma_seq_hv_cnt
    import chroma_pkg::*;
#(
    parameter int unsigned H_TOTAL_PAL  = DEF_H_TOTAL_PAL,
    parameter int unsigned H_TOTAL_NTSC = DEF_H_TOTAL_NTSC,
    parameter int unsigned V_TOTAL_PAL  = DEF_V_TOTAL_PAL,
    parameter int unsigned V_TOTAL_NTSC = DEF_V_TOTAL_NTSC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pnsel,
    output logic [HCNT_W-1:0] o_hcnt,
    output logic [VCNT_W-1:0] o_vcnt,
    output logic              o_line_start,
    output logic              o_field_start
);

    localparam logic [HCNT_W-1:0] L_HMAX_PAL  = HCNT_W'(H_TOTAL_PAL - 1);
    localparam logic [HCNT_W-1:0] L_HMAX_NTSC = HCNT_W'(H_TOTAL_NTSC - 1);
    localparam logic [VCNT_W-1:0] L_VMAX_PAL  = VCNT_W'(V_TOTAL_PAL - 1);
    localparam logic [VCNT_W-1:0] L_VMAX_NTSC = VCNT_W'(V_TOTAL_NTSC - 1);

    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic              w_hlast;
    logic              w_vlast;

    // i_pnsel only changes at field start, so a line never mixes lengths.
    always_comb begin
        w_hlast = (r_hcnt == ((i_pnsel == PNSEL_NTSC) ? L_HMAX_NTSC : L_HMAX_PAL));
        w_vlast = (r_vcnt == ((i_pnsel == PNSEL_NTSC) ? L_VMAX_NTSC : L_VMAX_PAL));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_hlast) begin
            r_hcnt <= '0;
            r_vcnt <= w_vlast ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_line_start  = (r_hcnt == '0);
    assign o_field_start = (r_hcnt == '0) && (r_vcnt == '0);

endmodule

// File: rtl/chroma_seq.sv
// ----------------------------------------------------------------------------
// chroma_seq
// Line/field sequencer for chroma_gen: composite sync, burst gate, colour
// window, PAL V-switch and the latched PAL/NTSC select.
//   cs_clock       in   pixel clock, rising edge
//   cs_reset_n     in   synchronous active-low reset
//   cs_pnsel_req   in   requested standard (0=PAL, 1=NTSC), taken at field start
//   cs_color_req   in   colour allowed, taken at line start
//   cs_hsync       out  composite sync, active low (broad pulses on vsync lines)
//   cs_burst       out  burst gate, active high
//   cs_enable      out  colour-enable window
//   cs_pnsel       out  standard in effect
//   cs_oddeven     out  PAL V-switch, 0 in NTSC
//   cs_field       out  toggles at every field start
//   cs_vcnt        out  current line number
// All outputs are registered and trail the position counter by one clock.
// ----------------------------------------------------------------------------
module chroma_seq
    import chroma_pkg::*;
#(
    parameter int unsigned H_TOTAL_PAL  = DEF_H_TOTAL_PAL,
    parameter int unsigned H_TOTAL_NTSC = DEF_H_TOTAL_NTSC,
    parameter int unsigned HSYNC_LEN    = DEF_HSYNC_LEN,
    parameter int unsigned BURST_START  = DEF_BURST_START,
    parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
    parameter int unsigned ACTIVE_START = DEF_ACTIVE_START,
    parameter int unsigned ACTIVE_END   = DEF_ACTIVE_END,
    parameter int unsigned V_TOTAL_PAL  = DEF_V_TOTAL_PAL,
    parameter int unsigned V_TOTAL_NTSC = DEF_V_TOTAL_NTSC,
    parameter int unsigned VSYNC_LINES  = DEF_VSYNC_LINES
) (
    input  logic              cs_clock,
    input  logic              cs_reset_n,
    input  logic              cs_pnsel_req,
    input  logic              cs_color_req,
    output logic              cs_hsync,
    output logic              cs_burst,
    output logic              cs_enable,
    output logic              cs_pnsel,
    output logic              cs_oddeven,
    output logic              cs_field,
    output logic [VCNT_W-1:0] cs_vcnt
);

    if (!(HSYNC_LEN >= 1 && BURST_LEN >= 1 &&
          HSYNC_LEN < BURST_START &&
          BURST_START + BURST_LEN <= ACTIVE_START &&
          ACTIVE_START < ACTIVE_END &&
          ACTIVE_END <= umin(H_TOTAL_PAL, H_TOTAL_NTSC) &&
          VSYNC_LINES < umin(V_TOTAL_PAL, V_TOTAL_NTSC) &&
          H_TOTAL_PAL <= (1 << HCNT_W) && H_TOTAL_NTSC <= (1 << HCNT_W) &&
          V_TOTAL_PAL <= (1 << VCNT_W) && V_TOTAL_NTSC <= (1 << VCNT_W))) begin : g_bad_timing
        $error("chroma_seq: illegal timing parameters");
    end

    localparam logic [HCNT_W-1:0] L_HSYNC_END  = HCNT_W'(HSYNC_LEN);
    localparam logic [HCNT_W-1:0] L_BURST_BEG  = HCNT_W'(BURST_START);
    localparam logic [HCNT_W-1:0] L_BURST_END  = HCNT_W'(BURST_START + BURST_LEN);
    localparam logic [HCNT_W-1:0] L_ACTIVE_BEG = HCNT_W'(ACTIVE_START);
    localparam logic [HCNT_W-1:0] L_ACTIVE_END = HCNT_W'(ACTIVE_END);
    localparam logic [HCNT_W-1:0] L_BROAD_PAL  = HCNT_W'(H_TOTAL_PAL - HSYNC_LEN);
    localparam logic [HCNT_W-1:0] L_BROAD_NTSC = HCNT_W'(H_TOTAL_NTSC - HSYNC_LEN);
    localparam logic [VCNT_W-1:0] L_VSYNC_END  = VCNT_W'(VSYNC_LINES);

    logic [HCNT_W-1:0] w_hcnt;
    logic [VCNT_W-1:0] w_vcnt;
    logic              w_line_start;
    logic              w_field_start;
    logic              w_vsync_line;
    logic              w_pnsel_nxt;
    seg_e              w_seg_nxt;

    seg_e              r_seg;
    logic              r_pnsel;
    logic              r_color;
    logic              r_field;
    logic              r_oddeven;
    logic              r_hsync;
    logic              r_burst;
    logic              r_enable;
    logic [VCNT_W-1:0] r_vcnt;

    chroma_seq_hv_cnt #(
        .H_TOTAL_PAL  (H_TOTAL_PAL),
        .H_TOTAL_NTSC (H_TOTAL_NTSC),
        .V_TOTAL_PAL  (V_TOTAL_PAL),
        .V_TOTAL_NTSC (V_TOTAL_NTSC)
    ) u_hv_cnt (
        .i_clk         (cs_clock),
        .i_rst_n       (cs_reset_n),
        .i_pnsel       (r_pnsel),
        .o_hcnt        (w_hcnt),
        .o_vcnt        (w_vcnt),
        .o_line_start  (w_line_start),
        .o_field_start (w_field_start)
    );

    // r_seg holds the segment of the previous hcnt; w_seg_nxt is the segment
    // of the current hcnt, which is what gets registered onto the outputs.
    always_comb begin
        w_seg_nxt = r_seg;
        if (w_line_start) begin
            w_seg_nxt = SEG_SYNC;
        end else begin
            unique case (r_seg)
                SEG_SYNC:   if (w_hcnt == L_HSYNC_END) w_seg_nxt = SEG_PORCH;
                SEG_PORCH: begin
                    if (w_hcnt == L_BURST_BEG)       w_seg_nxt = SEG_BURST;
                    else if (w_hcnt == L_ACTIVE_BEG) w_seg_nxt = SEG_ACTIVE;
                end
                // A zero-length back porch goes straight from burst to active.
                SEG_BURST:  if (w_hcnt == L_BURST_END)
                                w_seg_nxt = (L_BURST_END == L_ACTIVE_BEG) ? SEG_ACTIVE : SEG_PORCH;
                SEG_ACTIVE: if (w_hcnt == L_ACTIVE_END) w_seg_nxt = SEG_FRONT;
                SEG_FRONT:  w_seg_nxt = SEG_FRONT;
                default:    w_seg_nxt = SEG_SYNC;
            endcase
        end
    end

    always_comb begin
        w_pnsel_nxt  = w_field_start ? cs_pnsel_req : r_pnsel;
        w_vsync_line = (w_vcnt < L_VSYNC_END);
    end

    // Colour at hcnt 0 uses the previous line's r_color, harmless because the
    // segment there is always SYNC.
    always_ff @(posedge cs_clock) begin
        if (!cs_reset_n) begin
            r_seg     <= SEG_SYNC;
            r_pnsel   <= PNSEL_PAL;
            r_color   <= 1'b0;
            r_field   <= 1'b0;
            r_oddeven <= 1'b0;
            r_hsync   <= 1'b1;
            r_burst   <= 1'b0;
            r_enable  <= 1'b0;
            r_vcnt    <= '0;
        end else begin
            r_seg   <= w_seg_nxt;
            r_pnsel <= w_pnsel_nxt;
            r_vcnt  <= w_vcnt;
            if (w_field_start) begin
                r_field <= ~r_field;
            end
            if (w_line_start) begin
                r_color   <= cs_color_req;
                // Uses the freshly latched standard so a PAL->NTSC switch clears it.
                r_oddeven <= (w_pnsel_nxt == PNSEL_NTSC) ? 1'b0 : ~r_oddeven;
            end
            if (w_vsync_line) begin
                r_hsync <= (w_hcnt >= ((r_pnsel == PNSEL_NTSC) ? L_BROAD_NTSC : L_BROAD_PAL));
            end else begin
                r_hsync <= (w_seg_nxt != SEG_SYNC);
            end
            r_burst  <= (w_seg_nxt == SEG_BURST)  && r_color && !w_vsync_line;
            r_enable <= (w_seg_nxt == SEG_ACTIVE) && r_color && !w_vsync_line;
        end
    end

    assign cs_hsync   = r_hsync;
    assign cs_burst   = r_burst;
    assign cs_enable  = r_enable;
    assign cs_pnsel   = r_pnsel;
    assign cs_oddeven = r_oddeven;
    assign cs_field   = r_field;
    assign cs_vcnt    = r_vcnt;

endmodule

// File: tb/tb_chroma_seq.sv
// ----------------------------------------------------------------------------
// tb_chroma_seq
// Two sequencers share one clock: u_full with default 28 MHz timing for line
// level behaviour, u_small with a shrunken raster so whole fields and random
// standard changes fit in a short run. Both are compared every cycle against
// a position-based reference model.
// ----------------------------------------------------------------------------
module tb_chroma_seq;

    localparam int unsigned S_HT_PAL  = 64;
    localparam int unsigned S_HT_NTSC = 60;
    localparam int unsigned S_HS      = 6;
    localparam int unsigned S_BS      = 8;
    localparam int unsigned S_BL      = 4;
    localparam int unsigned S_AS      = 14;
    localparam int unsigned S_AE      = 56;
    localparam int unsigned S_VT_PAL  = 12;
    localparam int unsigned S_VT_NTSC = 10;
    localparam int unsigned S_VS      = 3;

    logic clk;
    logic rst_n   [2];
    logic pn_req  [2];
    logic col_req [2];

    logic       hs0, bu0, en0, ps0, oe0, fd0;
    logic       hs1, bu1, en1, ps1, oe1, fd1;
    logic [8:0] vc0, vc1;
    logic [14:0] obs0, obs1;

    assign obs0 = {hs0, bu0, en0, ps0, oe0, fd0, vc0};
    assign obs1 = {hs1, bu1, en1, ps1, oe1, fd1, vc1};

    chroma_seq u_full (
        .cs_clock     (clk),
        .cs_reset_n   (rst_n[0]),
        .cs_pnsel_req (pn_req[0]),
        .cs_color_req (col_req[0]),
        .cs_hsync     (hs0),
        .cs_burst     (bu0),
        .cs_enable    (en0),
        .cs_pnsel     (ps0),
        .cs_oddeven   (oe0),
        .cs_field     (fd0),
        .cs_vcnt      (vc0)
    );

    chroma_seq #(
        .H_TOTAL_PAL  (S_HT_PAL),
        .H_TOTAL_NTSC (S_HT_NTSC),
        .HSYNC_LEN    (S_HS),
        .BURST_START  (S_BS),
        .BURST_LEN    (S_BL),
        .ACTIVE_START (S_AS),
        .ACTIVE_END   (S_AE),
        .V_TOTAL_PAL  (S_VT_PAL),
        .V_TOTAL_NTSC (S_VT_NTSC),
        .VSYNC_LINES  (S_VS)
    ) u_small (
        .cs_clock     (clk),
        .cs_reset_n   (rst_n[1]),
        .cs_pnsel_req (pn_req[1]),
        .cs_color_req (col_req[1]),
        .cs_hsync     (hs1),
        .cs_burst     (bu1),
        .cs_enable    (en1),
        .cs_pnsel     (ps1),
        .cs_oddeven   (oe1),
        .cs_field     (fd1),
        .cs_vcnt      (vc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    endtask

    // Raster description per instance.
    int c_htp [2], c_htn [2], c_hs [2], c_bs [2], c_bl [2];
    int c_as  [2], c_ae  [2], c_vtp[2], c_vtn[2], c_vs [2];

    // Reference model: raster position plus per-field/per-line latched state.
    int          mh    [2];
    int          mv    [2];
    bit          mmode [2];
    bit          mfield[2];
    bit          moe   [2];
    bit          mcol  [2];
    logic [14:0] mexp  [2];

    task automatic model_edge(input int k);
        int ht, vt;
        bit vsl, hsx, bux, enx;
        if (!rst_n[k]) begin
            mh[k] = 0; mv[k] = 0;
            mmode[k] = 0; mfield[k] = 0; moe[k] = 0; mcol[k] = 0;
            mexp[k] = 15'h4000;
            return;
        end
        if (mh[k] == 0) begin
            if (mv[k] == 0) begin
                mmode[k]  = pn_req[k];
                mfield[k] = !mfield[k];
            end
            mcol[k] = col_req[k];
            moe[k]  = mmode[k] ? 1'b0 : !moe[k];
        end
        ht  = mmode[k] ? c_htn[k] : c_htp[k];
        vt  = mmode[k] ? c_vtn[k] : c_vtp[k];
        vsl = mv[k] < c_vs[k];
        hsx = vsl ? (mh[k] >= ht - c_hs[k]) : (mh[k] >= c_hs[k]);
        bux = mcol[k] && !vsl && mh[k] >= c_bs[k] && mh[k] < c_bs[k] + c_bl[k];
        enx = mcol[k] && !vsl && mh[k] >= c_as[k] && mh[k] < c_ae[k];
        mexp[k] = {hsx, bux, enx, mmode[k], moe[k], mfield[k], 9'(mv[k])};
        mh[k]++;
        if (mh[k] == ht) begin
            mh[k] = 0;
            mv[k]++;
            if (mv[k] == vt) mv[k] = 0;
        end
    endtask

    // Run-length measurements on u_full outputs.
    int q_hs[$], q_bu[$], q_en[$], q_per[$];
    int hs_run, bu_run, en_run, since_fall;
    bit prev_hs, per_on;

    task automatic clear_meas();
        q_hs.delete(); q_bu.delete(); q_en.delete(); q_per.delete();
        hs_run = 0; bu_run = 0; en_run = 0; since_fall = 0;
        prev_hs = 1'b1; per_on = 1'b0;
    endtask

    task automatic meas_full();
        if (!rst_n[0]) return;
        if (!hs0) hs_run++;
        else if (hs_run != 0) begin q_hs.push_back(hs_run); hs_run = 0; end
        if (bu0) bu_run++;
        else if (bu_run != 0) begin q_bu.push_back(bu_run); bu_run = 0; end
        if (en0) en_run++;
        else if (en_run != 0) begin q_en.push_back(en_run); en_run = 0; end
        if (prev_hs && !hs0) begin
            if (per_on) q_per.push_back(since_fall);
            since_fall = 0;
            per_on = 1'b1;
        end
        since_fall++;
        prev_hs = hs0;
    endtask

    // Lines per field on u_small, judged from its own field toggles.
    bit fs_prev_fd, fs_prev_ps, fs_seen;
    int fs_max_vc;

    task automatic meas_small();
        if (!rst_n[1]) begin
            fs_prev_fd = 1'b0; fs_prev_ps = 1'b0; fs_seen = 1'b0; fs_max_vc = 0;
            return;
        end
        if (fd1 != fs_prev_fd) begin
            if (fs_seen) check("field_lines", 32'(fs_max_vc + 1), fs_prev_ps ? S_VT_NTSC : S_VT_PAL);
            fs_seen   = 1'b1;
            fs_max_vc = 0;
        end
        if (int'(vc1) > fs_max_vc) fs_max_vc = int'(vc1);
        fs_prev_fd = fd1;
        fs_prev_ps = ps1;
    endtask

    task automatic drive_small();
        col_req[1] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 299) == 0) pn_req[1] = !pn_req[1];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("out_full",  32'(obs0), 32'(mexp[0]));
        check("out_small", 32'(obs1), 32'(mexp[1]));
        meas_full();
        meas_small();
        cyc++;
    endtask

    task automatic check_runs(input int broad, input int period, input int n_colour_lines);
        check("hsync_runs", q_hs.size(), 5);
        for (int i = 0; i < q_hs.size() && i < 5; i++)
            check("hsync_low_len", q_hs[i], (i < 3) ? broad : 132);
        check("periods", q_per.size(), 4);
        foreach (q_per[i]) check("line_period", q_per[i], period);
        check("burst_runs", q_bu.size(), n_colour_lines);
        foreach (q_bu[i]) check("burst_len", q_bu[i], 63);
        check("enable_runs", q_en.size(), n_colour_lines);
        foreach (q_en[i]) check("enable_len", q_en[i], 1453);
    endtask

    initial begin
        c_htp[0] = 1792; c_htn[0] = 1778; c_hs[0] = 132; c_bs[0] = 157; c_bl[0] = 63;
        c_as[0]  = 294;  c_ae[0]  = 1747; c_vtp[0] = 312; c_vtn[0] = 262; c_vs[0] = 3;
        c_htp[1] = S_HT_PAL; c_htn[1] = S_HT_NTSC; c_hs[1] = S_HS; c_bs[1] = S_BS; c_bl[1] = S_BL;
        c_as[1]  = S_AS;     c_ae[1]  = S_AE;      c_vtp[1] = S_VT_PAL; c_vtn[1] = S_VT_NTSC; c_vs[1] = S_VS;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; pn_req[k] = 1'b0; col_req[k] = 1'b0; mexp[k] = 15'h4000;
        end
        clear_meas();

        // Reset, then five PAL lines with colour on: three broad-pulse lines
        // followed by two normal lines.
        repeat (3) begin drive_small(); step(); end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1; col_req[0] = 1'b1;
        clear_meas();
        repeat (5 * 1792) begin drive_small(); step(); end
        check_runs(1660, 1792, 2);

        // Random colour requests within lines; end part-way through a line.
        repeat (3 * 1792 + 500) begin
            col_req[0] = 1'($urandom_range(0, 1));
            drive_small();
            step();
        end

        // Mid-line reset: outputs return to reset values on the next edge.
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        step();
        check("reset_full",  32'(obs0), 32'h4000);
        check("reset_small", 32'(obs1), 32'h4000);
        step();

        // NTSC from the first field, colour off.
        pn_req[0] = 1'b1; col_req[0] = 1'b0;
        clear_meas();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (5 * 1778) begin drive_small(); step(); end
        check_runs(1646, 1778, 0);
        check("ntsc_pnsel",   32'(ps0), 32'd1);
        check("ntsc_oddeven", 32'(oe0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
